// File: rtl/raw10_depacker.sv
// RAW10 depacker: 4-lane CSI-2 payload words (4 bytes/cycle) to 4x10-bit pixel groups.
// Five accepted words yield four groups; the phase tracks position in that 5-word cycle.
module raw10_depacker #(
    parameter int CNT_W = 12
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             line_valid_i,
    input  logic             data_valid_i,
    input  logic [31:0]      data_i,
    output logic             line_valid_o,
    output logic             data_valid_o,
    output logic [39:0]      data_o,
    output logic [CNT_W-1:0] group_count_o,
    output logic             align_err_o
);

    typedef enum logic [2:0] {
        PH0 = 3'd0,
        PH1 = 3'd1,
        PH2 = 3'd2,
        PH3 = 3'd3,
        PH4 = 3'd4
    } phase_t;

    phase_t      phase;
    phase_t      phase_nxt;
    logic [31:0] hold;
    logic [31:0] hold_nxt;
    logic        lv_q;
    logic        accept;
    logic        line_end;
    logic        line_start;
    logic        emit;
    logic [39:0] group;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;

    // Four MSB bytes plus the shared LSB byte form one pixel group.
    function automatic logic [39:0] pack(
        input logic [7:0] m0,
        input logic [7:0] m1,
        input logic [7:0] m2,
        input logic [7:0] m3,
        input logic [7:0] l
    );
        return {m0, l[1:0], m1, l[3:2], m2, l[5:4], m3, l[7:6]};
    endfunction

    assign b0         = data_i[7:0];
    assign b1         = data_i[15:8];
    assign b2         = data_i[23:16];
    assign b3         = data_i[31:24];
    assign accept     = data_valid_i & line_valid_i;
    assign line_end   = lv_q & ~line_valid_i;
    assign line_start = ~lv_q & line_valid_i;

    assign line_valid_o = lv_q;

    always_comb begin
        phase_nxt = phase;
        hold_nxt  = hold;
        emit      = 1'b0;
        group     = '0;
        if (line_end) begin
            phase_nxt = PH0;
            hold_nxt  = '0;
        end else if (accept) begin
            // hold keeps pending MSB bytes packed from bit 0 upward
            unique case (phase)
                PH0: begin
                    hold_nxt  = data_i;
                    phase_nxt = PH1;
                end
                PH1: begin
                    emit      = 1'b1;
                    group     = pack(hold[7:0], hold[15:8],
                                     hold[23:16], hold[31:24], b0);
                    hold_nxt  = {8'h00, b3, b2, b1};
                    phase_nxt = PH2;
                end
                PH2: begin
                    emit      = 1'b1;
                    group     = pack(hold[7:0], hold[15:8],
                                     hold[23:16], b0, b1);
                    hold_nxt  = {16'h0000, b3, b2};
                    phase_nxt = PH3;
                end
                PH3: begin
                    emit      = 1'b1;
                    group     = pack(hold[7:0], hold[15:8], b0, b1, b2);
                    hold_nxt  = {24'h000000, b3};
                    phase_nxt = PH4;
                end
                PH4: begin
                    emit      = 1'b1;
                    group     = pack(hold[7:0], b0, b1, b2, b3);
                    hold_nxt  = '0;
                    phase_nxt = PH0;
                end
                default: begin
                    hold_nxt  = '0;
                    phase_nxt = PH0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            phase <= PH0;
            hold  <= '0;
        end else begin
            phase <= phase_nxt;
            hold  <= hold_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            lv_q          <= 1'b0;
            data_valid_o  <= 1'b0;
            data_o        <= '0;
            group_count_o <= '0;
            align_err_o   <= 1'b0;
        end else begin
            lv_q         <= line_valid_i;
            data_valid_o <= emit;
            align_err_o  <= line_end && (phase != PH0);
            if (emit) begin
                data_o <= group;
            end
            if (line_start) begin
                group_count_o <= '0;
            end else if (emit && (group_count_o != '1)) begin
                group_count_o <= group_count_o + 1'b1;
            end
        end
    end

endmodule
